// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude shift-add multiply and
// restoring divide, one radix-2 step per cycle, with divide special cases resolved at accept.
//
// state | meaning
// IDLE  | ready for a new op
// CALC  | iterating, one step per cycle
// DONE  | result held until consumer takes it
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic            acc_sgn_a, acc_sgn_b;
  logic            acc_neg_a, acc_neg_b;
  logic [XLEN-1:0] acc_mag_a, acc_mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_try;
  logic              div_ge;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fin_res;

  // Accept-time decode; op[2] selects divide, op[0] marks the unsigned divide flavours.
  always_comb begin
    acc_sgn_a = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    acc_sgn_b = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
    acc_neg_a = acc_sgn_a & bus.a[XLEN-1];
    acc_neg_b = acc_sgn_b & bus.b[XLEN-1];
    acc_mag_a = acc_neg_a ? -bus.a : bus.a;
    acc_mag_b = acc_neg_b ? -bus.b : bus.b;
    div_zero  = bus.op[2] & (bus.b == '0);
    div_ovf   = bus.op[2] & ~bus.op[0] & (bus.a == MIN_NEG) & (bus.b == '1);
    if (div_zero) begin
      spec_res = bus.op[1] ? bus.a : '1;
    end else begin
      spec_res = bus.op[1] ? '0 : bus.a;
    end
  end

  // One iteration: multiply shifts the product right through hi/lo, divide shifts the
  // dividend left out of lo into the partial remainder in hi.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_try   = div_shift[XLEN-1:0] - opnd_q;
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (op_q[2]) begin
      step_hi = div_ge ? div_try : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_s  = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
    rem_s  = neg_a_q ? -step_hi : step_hi;
    unique case (op_q)
      3'd0:       fin_res = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fin_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5: fin_res = quo_s;
      default:    fin_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          neg_a_d = acc_neg_a;
          neg_b_d = acc_neg_b;
          if (div_zero || div_ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            hi_d    = '0;
            lo_d    = bus.op[2] ? acc_mag_a : acc_mag_b;
            opnd_d  = bus.op[2] ? acc_mag_b : acc_mag_a;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = fin_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush drops everything, including a pending handshake, but never disturbs res.
    if (bus.flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res       = res_q;

endmodule
